// File: rtl/enc_pkg.sv
// Shared types and helpers for the sequential priority encoder.
package enc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } enc_state_t;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_idx.sv
// Combinational find-first-set over a request vector.
// Scan direction: LSB-first by default, MSB-first when ENC_MSB_FIRST_EN is defined.
module prio_idx
    import enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         one_left
);

    always_comb begin
        idx = '0;
`ifdef ENC_MSB_FIRST_EN
        for (int i = 0; i < N; i++) begin
            if (vec[i]) idx = W'(i);
        end
`else
        // Scan downwards so the lowest set bit is the final (winning) assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
`endif
    end

    // Clearing the lowest set bit leaves zero iff at most one bit was set.
    assign one_left = ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/pri_encoder_seq.sv
// Sequential priority encoder: accepts an N-bit request vector and emits one index per beat.
// Build option ENC_MSB_FIRST_EN (in prio_idx) makes the MSB highest priority.
module pri_encoder_seq
    import enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic [W-1:0] y,
    output logic         y_valid,
    input  logic         y_ready,
    output logic         last,
    output logic         none,
    output enc_state_t   state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and an offered beat holds stable until it is taken.

    logic [N-1:0] pending;
    logic [W-1:0] idx;
    logic         one_left;
    logic [N-1:0] clr_mask;

    prio_idx #(.N(N), .W(W)) u_prio_idx (
        .vec      (pending),
        .idx      (idx),
        .one_left (one_left)
    );

    assign y_valid   = (state == DRAIN);
    assign y         = y_valid ? idx : '0;
    assign last      = y_valid & one_left;
    assign none      = y_valid & (pending == '0);
    assign din_ready = (state == IDLE) | (y_valid & y_ready & last);
    assign clr_mask  = N'(1) << idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
        end else if (din_valid && din_ready) begin
            // Covers both IDLE and the zero-bubble reload on a last beat.
            pending <= din;
            state   <= DRAIN;
        end else if (y_valid && y_ready) begin
            pending <= pending & ~clr_mask;
            if (last) state <= IDLE;
        end
    end

endmodule

// File: tb/tb_pri_encoder_seq.sv
// Bench for pri_encoder_seq: directed scenarios with literal expectations plus random traffic
// checked every cycle against a beat-list model.
module tb_pri_encoder_seq;
    import enc_pkg::*;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic [W-1:0] y;
    logic         y_valid;
    logic         y_ready;
    logic         last;
    logic         none;
    enc_state_t   state;

    int checks = 0;
    int passes = 0;

    pri_encoder_seq #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .y         (y),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .last      (last),
        .none      (none),
        .state     (state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // ---------------- model: list of beats still owed for the current vector ----------------
    logic [W-1:0] exp_q[$];
    bit           none_q[$];
    bit           check_en = 1'b0;
    bit           m_busy, m_rdy;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            none_q.delete();
            check_en = 1'b1;
        end else begin
            m_busy = (exp_q.size() != 0);
            m_rdy  = !m_busy || (y_ready && exp_q.size() == 1);
            if (m_busy && y_ready) begin
                void'(exp_q.pop_front());
                void'(none_q.pop_front());
            end
            if (din_valid && m_rdy) begin
                if (din == '0) begin
                    exp_q.push_back('0);
                    none_q.push_back(1'b1);
                end else begin
`ifdef ENC_MSB_FIRST_EN
                    for (int i = N - 1; i >= 0; i--)
`else
                    for (int i = 0; i < N; i++)
`endif
                        if (din[i]) begin
                            exp_q.push_back(W'(i));
                            none_q.push_back(1'b0);
                        end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [7:0] act_v, exp_v;
    always @(negedge clk) begin
        if (check_en) begin
            if (exp_q.size() != 0)
                exp_v = {1'b1, exp_q[0], exp_q.size() == 1, none_q[0],
                         y_ready && exp_q.size() == 1, 1'b1};
            else
                exp_v = {1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0};
            act_v = {y_valid, y, last, none, din_ready, state == DRAIN};
            chk("cycle{yv,y,last,none,rdy,drain}", 32'(act_v), 32'(exp_v));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents vec until accepted; returns 1 ns after the accepting edge with din_valid low.
    task automatic send(input logic [N-1:0] vec);
        int budget;
        din = vec;
        din_valid = 1'b1;
        budget = 50;
        @(negedge clk);
        while (!din_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            $display("FAIL send_timeout: got din_ready=0 required 1");
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] exp3[3];
    logic [W-1:0] exp4[2];

    initial begin
`ifdef ENC_MSB_FIRST_EN
        exp3 = '{3'd7, 3'd4, 3'd2};
        exp4 = '{3'd3, 3'd1};
`else
        exp3 = '{3'd2, 3'd4, 3'd7};
        exp4 = '{3'd1, 3'd3};
`endif
        // 1: reset with din_valid held high
        rst = 1'b1; din = 8'h5A; din_valid = 1'b1; y_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_y_valid", 32'(y_valid), 0);
        chk("reset_y", 32'(y), 0);
        rst = 1'b0; din_valid = 1'b0;
        @(negedge clk);
        chk("post_reset_din_ready", 32'(din_ready), 1);
        chk("post_reset_y_valid", 32'(y_valid), 0);

        // 2: single bit
        send(8'b0000_0001);
        @(negedge clk);
        chk("single_y_valid", 32'(y_valid), 1);
        chk("single_y", 32'(y), 0);
        chk("single_last", 32'(last), 1);
        chk("single_none", 32'(none), 0);
        @(negedge clk);
        chk("single_done_y_valid", 32'(y_valid), 0);
        chk("single_done_din_ready", 32'(din_ready), 1);
        idle(2);

        // 3: multi-bit
        send(8'b1001_0100);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("multi_y", 32'(y), 32'(exp3[k]));
            chk("multi_last", 32'(last), (k == 2) ? 1 : 0);
        end
        idle(2);

        // 4: backpressure
        y_ready = 1'b0;
        send(8'b0000_1010);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_y_valid", 32'(y_valid), 1);
            chk("bp_y_held", 32'(y), 32'(exp4[0]));
            chk("bp_last", 32'(last), 0);
        end
        y_ready = 1'b1;
        @(negedge clk);
        chk("bp_second_y", 32'(y), 32'(exp4[1]));
        chk("bp_second_last", 32'(last), 1);
        idle(2);

        // 5: empty vector, then back-to-back accept on its beat
        din = 8'h00; din_valid = 1'b1;
        @(posedge clk);
        #1 din = 8'h80;
        @(negedge clk);
        chk("empty_y_valid", 32'(y_valid), 1);
        chk("empty_y", 32'(y), 0);
        chk("empty_none", 32'(none), 1);
        chk("empty_last", 32'(last), 1);
        chk("empty_din_ready", 32'(din_ready), 1);
        @(posedge clk);
        #1 din_valid = 1'b0;
        @(negedge clk);
        chk("b2b_y_valid", 32'(y_valid), 1);
        chk("b2b_y", 32'(y), 7);
        chk("b2b_none", 32'(none), 0);
        idle(2);

        // 6: reset during drain after the third beat
        send(8'hFF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
`ifdef ENC_MSB_FIRST_EN
            chk("ff_y", 32'(y), 32'(7 - k));
`else
            chk("ff_y", 32'(y), 32'(k));
`endif
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_y_valid", 32'(y_valid), 0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midreset_no_beats", 32'(y_valid), 0);
        end

        // random traffic, checked by the per-cycle compare
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            case ($urandom_range(0, 4))
                0:       din = '0;
                1:       din = N'(1) << $urandom_range(0, N - 1);
                default: din = N'($urandom);
            endcase
            din_valid = ($urandom_range(0, 2) != 0);
            y_ready   = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 80) == 0);
        end
        rst = 1'b0;
        idle(20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
